// File: rtl/dwt_row_extender.sv
// Buffers one row of LEN samples, then replays it with 4-sample whole-sample
// symmetric extension on each side (LEN+8 samples) for a 9/7 lifting transform.
module dwt_row_extender #(
   parameter int size = 32,
   parameter int LEN  = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [size-1:0] in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [size-1:0] x,
   output logic            x_valid,
   input  logic            x_ready,
   output logic            x_first,
   output logic            x_last,
   output logic            x_odd,
   output logic            row_done
);

   localparam int RW = $clog2(LEN + 8) + 1;
   localparam int AW = (LEN > 1) ? $clog2(LEN) : 1;

   localparam logic signed [RW-1:0] IDX_FIRST = RW'(-4);
   localparam logic signed [RW-1:0] IDX_LAST  = RW'(LEN + 3);
   localparam logic signed [RW-1:0] IDX_ZERO  = '0;
   localparam logic signed [RW-1:0] IDX_TOP   = RW'(LEN - 1);
   localparam logic        [RW-1:0] MIRROR    = RW'(2 * (LEN - 1));
   localparam logic        [AW-1:0] WR_LAST   = AW'(LEN - 1);

   typedef enum logic {LOAD, EMIT} state_t;

   state_t               state, state_nx;
   logic [size-1:0]      mem [LEN];
   logic [AW-1:0]        wr_ptr;
   logic signed [RW-1:0] rd_idx;
   logic [AW-1:0]        rd_addr;
   logic                 accept;
   logic                 wr_last;
   logic                 emit_go;
   logic                 xfer_last;

   assign in_ready  = (state == LOAD) && !reset;
   assign accept    = in_valid && in_ready;
   assign wr_last   = (wr_ptr == WR_LAST);
   assign emit_go   = (state == EMIT) && (rd_idx <= IDX_LAST) && (!x_valid || x_ready);
   assign xfer_last = x_valid && x_ready && x_last;

   // Reflection is done modulo 2^RW and truncated; the results always land in 0..LEN-1.
   always_comb begin
      rd_addr = AW'(rd_idx);
      if (rd_idx < IDX_ZERO)
         rd_addr = AW'(-rd_idx);
      else if (rd_idx > IDX_TOP)
         rd_addr = AW'(MIRROR - rd_idx);
   end

   always_ff @(posedge clk) begin
      if (reset) state <= LOAD;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         LOAD:    if (accept && wr_last) state_nx = EMIT;
         EMIT:    if (xfer_last)         state_nx = LOAD;
         default: state_nx = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_idx   <= IDX_FIRST;
         x        <= '0;
         x_valid  <= 1'b0;
         x_first  <= 1'b0;
         x_last   <= 1'b0;
         x_odd    <= 1'b0;
         row_done <= 1'b0;
      end else begin
         row_done <= 1'b0;
         if (accept) begin
            if (wr_last) begin
               wr_ptr <= '0;
               rd_idx <= IDX_FIRST;
            end else begin
               wr_ptr <= wr_ptr + 1'b1;
            end
         end
         // rd_idx is already past LEN+3 when the last sample transfers, so these never overlap.
         if (emit_go) begin
            x       <= mem[rd_addr];
            x_valid <= 1'b1;
            x_first <= (rd_idx == IDX_FIRST);
            x_last  <= (rd_idx == IDX_LAST);
            x_odd   <= rd_idx[0];
            rd_idx  <= rd_idx + 1'b1;
         end else if (xfer_last) begin
            x_valid  <= 1'b0;
            x_first  <= 1'b0;
            x_last   <= 1'b0;
            row_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dwt_row_extender.sv
// Randomized scoreboard bench: rows are recorded as accepted, the extended
// sequence is computed from the reflection rule and checked by a separate monitor.
module tb_dwt_row_extender;

   localparam int SIZE = 32;
   localparam int LEN  = 8;

   typedef struct {
      logic [SIZE-1:0] v;
      logic            f;
      logic            l;
      logic            o;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [SIZE-1:0] in_data = '0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [SIZE-1:0] x;
   logic            x_valid;
   logic            x_ready = 1'b0;
   logic            x_first;
   logic            x_last;
   logic            x_odd;
   logic            row_done;

   dwt_row_extender #(.size(SIZE), .LEN(LEN)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .x(x), .x_valid(x_valid), .x_ready(x_ready),
      .x_first(x_first), .x_last(x_last), .x_odd(x_odd), .row_done(row_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   exp_t            exp_q [$];
   logic [SIZE-1:0] row_q [$];
   bit              load_flag = 0;
   bit              m_emit = 0;
   bit              m_done = 0;
   int              m_cnt = 0;
   int              xr_mode = 0;
   int              cyc_n = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: extended index e maps to row[-e], row[e] or row[2(LEN-1)-e].
   task automatic push_row();
      exp_t it;
      for (int e = -4; e <= LEN + 3; e++) begin
         int r;
         r = (e < 0) ? -e : (e >= LEN) ? 2 * (LEN - 1) - e : e;
         it.v = row_q[r];
         it.f = (e == -4);
         it.l = (e == LEN + 3);
         it.o = (e % 2 != 0);
         exp_q.push_back(it);
      end
      row_q.delete();
      load_flag = 1;
   endtask

   task automatic cyc(input logic iv, input logic [SIZE-1:0] d, input logic rst, output bit acc);
      @(posedge clk);
      #1;
      cyc_n++;
      in_valid = iv;
      in_data  = d;
      reset    = rst;
      case (xr_mode)
         0:       x_ready = 1'b1;
         1:       x_ready = (cyc_n % 3 == 0);
         default: x_ready = ($urandom_range(0, 99) < 60);
      endcase
      @(negedge clk);
      acc = 0;
      if (rst) row_q.delete();
      else if (in_valid && in_ready) begin
         acc = 1;
         row_q.push_back(in_data);
         if (row_q.size() == LEN) push_row();
      end
   endtask

   task automatic send_row(input logic [SIZE-1:0] vals [LEN], input int pv);
      int k = 0;
      int guard = 0;
      bit acc;
      while (k < LEN && guard < 2000) begin
         cyc(($urandom_range(0, 99) < pv), vals[k], 1'b0, acc);
         if (acc) k++;
         guard++;
      end
      if (k < LEN) begin
         errors++;
         $display("FAIL send_row_timeout: got %0d samples accepted, expected %0d", k, LEN);
      end
   endtask

   task automatic idle(input int n, input logic iv);
      bit acc;
      for (int i = 0; i < n; i++) cyc(iv, SIZE'($urandom), 1'b0, acc);
   endtask

   // Monitor
   initial begin
      exp_t            e;
      logic [SIZE-1:0] px;
      logic            pf, pl, po;
      bit              prev_stall = 0;
      bit              xl;
      px = '0; pf = 0; pl = 0; po = 0;
      forever begin
         @(negedge clk);
         #1;
         chk("in_ready", in_ready, !reset && !m_emit);
         chk("row_done", row_done, m_done);
         if (!m_emit || m_cnt == 0) chk("x_valid_idle", x_valid, 1'b0);
         else if (m_cnt == 1)       chk("x_valid_latency", x_valid, 1'b1);
         if (prev_stall) begin
            chk("hold_valid", x_valid, 1'b1);
            chk("hold_x", x, px);
            chk("hold_flags", {x_first, x_last, x_odd}, {pf, pl, po});
         end
         xl = 0;
         if (reset) begin
            exp_q.delete();
            m_emit = 0;
            load_flag = 0;
         end else begin
            if (x_valid && x_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_output: got x=%0h, expected no output", x);
               end else begin
                  e = exp_q.pop_front();
                  chk("x", x, e.v);
                  chk("x_first", x_first, e.f);
                  chk("x_last", x_last, e.l);
                  chk("x_odd", x_odd, e.o);
                  if (e.l) begin
                     xl = 1;
                     m_emit = 0;
                  end
               end
            end
            if (m_emit) m_cnt++;
            if (load_flag) begin
               m_emit = 1;
               m_cnt = 0;
               load_flag = 0;
            end
         end
         m_done = xl;
         prev_stall = !reset && x_valid && !x_ready;
         px = x; pf = x_first; pl = x_last; po = x_odd;
      end
   end

   // Stimulus
   initial begin
      logic [SIZE-1:0] vals [LEN];
      bit acc;
      int guard;
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, acc);

      // directed row 100..107, free-flowing then stalled 1,0,0
      for (int i = 0; i < LEN; i++) vals[i] = SIZE'(100 + i);
      xr_mode = 0; send_row(vals, 100); idle(20, 1'b0);
      xr_mode = 1; send_row(vals, 100); idle(50, 1'b0);

      // in_valid held high through EMIT with changing data
      for (int i = 0; i < LEN; i++) vals[i] = SIZE'($urandom);
      xr_mode = 0; send_row(vals, 100); idle(17, 1'b1);
      idle(30, 1'b0);

      // random rows with random handshakes
      xr_mode = 2;
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < LEN; i++) vals[i] = SIZE'($urandom);
         send_row(vals, 70);
      end
      idle(60, 1'b0);

      // reset mid-EMIT around the 7th output, then row 200..207
      xr_mode = 0;
      for (int i = 0; i < LEN; i++) vals[i] = SIZE'($urandom);
      send_row(vals, 100); idle(7, 1'b0);
      cyc(1'b0, '0, 1'b1, acc);
      for (int i = 0; i < LEN; i++) vals[i] = SIZE'(200 + i);
      send_row(vals, 100); idle(20, 1'b0);

      // reset mid-LOAD discards the partial row
      idle(3, 1'b1);
      cyc(1'b0, '0, 1'b1, acc);
      for (int i = 0; i < LEN; i++) vals[i] = SIZE'($urandom);
      send_row(vals, 100); idle(20, 1'b0);

      // back-to-back rows with in_valid always high
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < LEN; i++) vals[i] = SIZE'($urandom);
         send_row(vals, 100);
      end

      guard = 0;
      while ((exp_q.size() != 0 || m_emit || load_flag) && guard < 300) begin
         idle(1, 1'b0);
         guard++;
      end
      checks++;
      if (exp_q.size() != 0 || m_emit) begin
         errors++;
         $display("FAIL drain: got %0d outputs still pending, expected 0", exp_q.size());
      end
      idle(3, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
